// File: rtl/morse_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// morse_encoder
//   Pops ASCII characters from an 8-bit FIFO read port and keys them out as
//   on/off Morse timing on key_out. One Morse time unit is UNIT_CYCLES clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   fifo_empty FIFO empty flag (looked at only while idle)
//   fifo_dout  FIFO read data, valid the cycle after fifo_re
//   fifo_re    FIFO read enable, one-cycle pulse per character
//   key_out    Morse line, 1 = mark
//   busy       high whenever the encoder is not idle
//   char_done  one-cycle pulse on the last cycle of a character's trailing gap
//   bad_char   one-cycle pulse when an unsupported byte is discarded
// -----------------------------------------------------------------------------
module morse_encoder #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_re,
    output logic       key_out,
    output logic       busy,
    output logic       char_done,
    output logic       bad_char
);

    localparam logic [23:0] UNIT_LAST = 24'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MARK,
        S_EGAP,
        S_CGAP,
        S_WGAP
    } state_t;

    state_t      state;
    logic [23:0] cyc_cnt;
    logic [1:0]  unit_cnt;
    logic [4:0]  code_pat;   // remaining elements, current one in bit 4
    logic [2:0]  elem_left;  // elements still to send, including current

    // Returns {length, pattern}. Pattern is left-aligned so the first element
    // sits in bit 4; 1 = dash. Length 0 marks an unsupported character.
    function automatic logic [7:0] lookup(input logic [7:0] ch);
        logic [7:0] uc;
        uc = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        case (uc)
            8'h41: lookup = {3'd2, 5'b01000}; // A .-
            8'h42: lookup = {3'd4, 5'b10000}; // B -...
            8'h43: lookup = {3'd4, 5'b10100}; // C -.-.
            8'h44: lookup = {3'd3, 5'b10000}; // D -..
            8'h45: lookup = {3'd1, 5'b00000}; // E .
            8'h46: lookup = {3'd4, 5'b00100}; // F ..-.
            8'h47: lookup = {3'd3, 5'b11000}; // G --.
            8'h48: lookup = {3'd4, 5'b00000}; // H ....
            8'h49: lookup = {3'd2, 5'b00000}; // I ..
            8'h4A: lookup = {3'd4, 5'b01110}; // J .---
            8'h4B: lookup = {3'd3, 5'b10100}; // K -.-
            8'h4C: lookup = {3'd4, 5'b01000}; // L .-..
            8'h4D: lookup = {3'd2, 5'b11000}; // M --
            8'h4E: lookup = {3'd2, 5'b10000}; // N -.
            8'h4F: lookup = {3'd3, 5'b11100}; // O ---
            8'h50: lookup = {3'd4, 5'b01100}; // P .--.
            8'h51: lookup = {3'd4, 5'b11010}; // Q --.-
            8'h52: lookup = {3'd3, 5'b01000}; // R .-.
            8'h53: lookup = {3'd3, 5'b00000}; // S ...
            8'h54: lookup = {3'd1, 5'b10000}; // T -
            8'h55: lookup = {3'd3, 5'b00100}; // U ..-
            8'h56: lookup = {3'd4, 5'b00010}; // V ...-
            8'h57: lookup = {3'd3, 5'b01100}; // W .--
            8'h58: lookup = {3'd4, 5'b10010}; // X -..-
            8'h59: lookup = {3'd4, 5'b10110}; // Y -.--
            8'h5A: lookup = {3'd4, 5'b11000}; // Z --..
            8'h30: lookup = {3'd5, 5'b11111}; // 0
            8'h31: lookup = {3'd5, 5'b01111}; // 1
            8'h32: lookup = {3'd5, 5'b00111}; // 2
            8'h33: lookup = {3'd5, 5'b00011}; // 3
            8'h34: lookup = {3'd5, 5'b00001}; // 4
            8'h35: lookup = {3'd5, 5'b00000}; // 5
            8'h36: lookup = {3'd5, 5'b10000}; // 6
            8'h37: lookup = {3'd5, 5'b11000}; // 7
            8'h38: lookup = {3'd5, 5'b11100}; // 8
            8'h39: lookup = {3'd5, 5'b11110}; // 9
            default: lookup = 8'h00;
        endcase
    endfunction

    logic [7:0] lk;
    logic [2:0] lk_len;
    logic       is_space;
    logic       unit_end;
    logic [1:0] mark_last;
    logic       state_done;

    always_comb begin
        lk         = lookup(fifo_dout);
        lk_len     = lk[7:5];
        is_space   = (fifo_dout == 8'h20);
        unit_end   = (cyc_cnt == UNIT_LAST);
        // a dash spans three units, a dot one
        mark_last  = code_pat[4] ? 2'd2 : 2'd0;
        state_done = 1'b0;
        case (state)
            S_MARK:  state_done = unit_end && (unit_cnt == mark_last);
            S_EGAP:  state_done = unit_end;
            S_CGAP:  state_done = unit_end && (unit_cnt == 2'd2);
            S_WGAP:  state_done = unit_end && (unit_cnt == 2'd3);
            default: state_done = 1'b0;
        endcase
    end

    // Read request is combinational so the byte arrives exactly in FETCH.
    assign fifo_re   = (state == S_IDLE) && !fifo_empty && !rst;
    assign char_done = !rst && state_done && ((state == S_CGAP) || (state == S_WGAP));
    assign bad_char  = !rst && (state == S_FETCH) && !is_space && (lk_len == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            key_out  <= 1'b0;
            busy     <= 1'b0;
            cyc_cnt  <= 24'd0;
            unit_cnt <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cyc_cnt  <= 24'd0;
                    unit_cnt <= 2'd0;
                    if (!fifo_empty) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    cyc_cnt  <= 24'd0;
                    unit_cnt <= 2'd0;
                    if (is_space) begin
                        state <= S_WGAP;
                    end else if (lk_len != 3'd0) begin
                        state     <= S_MARK;
                        key_out   <= 1'b1;
                        code_pat  <= lk[4:0];
                        elem_left <= lk_len;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    // Timed states: counters restart on every state change.
                    if (state_done) begin
                        cyc_cnt  <= 24'd0;
                        unit_cnt <= 2'd0;
                    end else if (unit_end) begin
                        cyc_cnt  <= 24'd0;
                        unit_cnt <= unit_cnt + 2'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 24'd1;
                    end

                    if (state_done) begin
                        case (state)
                            S_MARK: begin
                                key_out   <= 1'b0;
                                code_pat  <= {code_pat[3:0], 1'b0};
                                elem_left <= elem_left - 3'd1;
                                state     <= (elem_left == 3'd1) ? S_CGAP : S_EGAP;
                            end
                            S_EGAP: begin
                                key_out <= 1'b1;
                                state   <= S_MARK;
                            end
                            default: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
`timescale 1ns/1ps
module tb_morse_encoder;

    localparam int U = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_re, key_out, busy, char_done, bad_char;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_re   (fifo_re),
        .key_out   (key_out),
        .busy      (busy),
        .char_done (char_done),
        .bad_char  (bad_char)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         bad;
        string      trace;
        logic [7:0] ch;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       re_s     = 1'b0;
    bit         prev_done = 1'b0;
    string      cur = "";

    string LET[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string DIG[10] = '{"-----", ".----", "..---", "...--", "....-",
                       ".....", "-....", "--...", "---..", "----."};

    task automatic chk(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected key_out per busy cycle: FETCH cycle first, then marks and gaps
    // up to and including the cycle carrying char_done / bad_char.
    function automatic string model(input logic [7:0] c, output bit bad);
        string m;
        string t;
        bad = 1'b0;
        t   = "0";
        if (c == 8'h20) begin
            repeat (4 * U) t = {t, "0"};
            return t;
        end
        if (c >= 8'h41 && c <= 8'h5A)      m = LET[int'(c) - 8'h41];
        else if (c >= 8'h61 && c <= 8'h7A) m = LET[int'(c) - 8'h61];
        else if (c >= 8'h30 && c <= 8'h39) m = DIG[int'(c) - 8'h30];
        else begin
            bad = 1'b1;
            return t;
        end
        for (int i = 0; i < m.len(); i++) begin
            repeat ((m[i] == 8'h2D) ? 3 * U : U) t = {t, "1"};
            if (i < m.len() - 1) repeat (U) t = {t, "0"};
        end
        repeat (3 * U) t = {t, "0"};
        return t;
    endfunction

    task automatic expect_char(input logic [7:0] c);
        exp_t e;
        e.ch    = c;
        e.trace = model(c, e.bad);
        exp_q.push_back(e);
    endtask

    task automatic push_char(input logic [7:0] c);
        fifo_q.push_back(c);
        fifo_empty = 1'b0;
        expect_char(c);
    endtask

    // One clock; the FIFO model pops on a read sampled before the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (re_s) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, {name, "_drain"}, $sformatf("%0d pending", exp_q.size()), "0 pending");
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        re_s = fifo_re;
        if (rst) begin
            cur       = "";
            prev_done = 1'b0;
            chk(fifo_re == 1'b0, "re_in_rst", $sformatf("%b", fifo_re), "0");
            chk(char_done == 1'b0, "done_in_rst", $sformatf("%b", char_done), "0");
        end else begin
            chk(fifo_re == (!busy && !fifo_empty), "fifo_re_rule",
                $sformatf("%b", fifo_re), $sformatf("%b", !busy && !fifo_empty));
            if (prev_done)
                chk(busy == 1'b0, "idle_after_done", $sformatf("%b", busy), "0");
            if (!busy)
                chk(key_out == 1'b0, "key_when_idle", $sformatf("%b", key_out), "0");
            if (busy) cur = {cur, key_out ? "1" : "0"};
            if (char_done && bad_char)
                chk(1'b0, "done_and_bad", "both high", "exclusive");
            if (char_done || bad_char) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", cur, "no event");
                end else begin
                    e = exp_q.pop_front();
                    chk(bad_char == e.bad, $sformatf("kind_%02h", e.ch),
                        bad_char ? "bad_char" : "char_done", e.bad ? "bad_char" : "char_done");
                    chk(cur == e.trace, $sformatf("trace_%02h", e.ch), cur, e.trace);
                end
                cur = "";
            end
            prev_done = char_done;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // reset values
        repeat (3) tick();
        chk(key_out == 1'b0, "rst_key", $sformatf("%b", key_out), "0");
        chk(busy == 1'b0, "rst_busy", $sformatf("%b", busy), "0");
        chk(fifo_re == 1'b0, "rst_re", $sformatf("%b", fifo_re), "0");
        chk(bad_char == 1'b0, "rst_bad", $sformatf("%b", bad_char), "0");
        rst = 1'b0;

        // empty FIFO for 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick();
            chk({fifo_re, key_out, busy} == 3'b000, "empty_idle",
                $sformatf("%b%b%b", fifo_re, key_out, busy), "000");
        end

        push_char(8'h45); drain(100, "E");
        push_char(8'h61); drain(100, "a");
        push_char(8'h41); drain(100, "A");
        push_char(8'h45); push_char(8'h20); push_char(8'h45); drain(200, "E_E");
        push_char(8'h23); push_char(8'h30); drain(200, "bad_0");

        // reset in the middle of the dash of 'T'
        push_char(8'h54);
        guard = 0;
        while (!key_out && guard < 20) begin tick(); guard++; end
        chk(key_out == 1'b1, "T_mark_start", $sformatf("%b", key_out), "1");
        tick(); tick();
        rst = 1'b1;
        exp_q.delete();
        fifo_q.push_back(8'h4B);
        fifo_empty = 1'b0;
        tick();
        chk(key_out == 1'b0, "rst_mid_key", $sformatf("%b", key_out), "0");
        chk(busy == 1'b0, "rst_mid_busy", $sformatf("%b", busy), "0");
        repeat (4) tick();
        rst = 1'b0;
        expect_char(8'h4B);
        drain(200, "after_rst");

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [7:0] c;
            case ($urandom_range(0, 9))
                0, 1, 2: c = 8'(8'h41 + $urandom_range(0, 25));
                3, 4:    c = 8'(8'h61 + $urandom_range(0, 25));
                5, 6:    c = 8'(8'h30 + $urandom_range(0, 9));
                7:       c = 8'h20;
                default: c = 8'($urandom_range(0, 255));
            endcase
            push_char(c);
            repeat ($urandom_range(0, 40)) tick();
        end
        drain(5000, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
